// File: rtl/btb_update_queue_if.sv
// Resolve-side and BTB-write-side signal bundle for btb_update_queue.
// The slave modport is the queue itself; the master modport is its environment.
interface btb_update_queue_if;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        update_ready;
  logic        update;
  logic [31:0] update_addr;
  logic [31:0] target_addr;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        full;
  logic [7:0]  drop_count;

  modport master (
    output resolve_valid, resolve_pc, resolve_taken, resolve_target,
    output pred_taken, pred_target, update_ready,
    input  update, update_addr, target_addr, mispredict, redirect_pc,
    input  full, drop_count
  );

  modport slave (
    input  resolve_valid, resolve_pc, resolve_taken, resolve_target,
    input  pred_taken, pred_target, update_ready,
    output update, update_addr, target_addr, mispredict, redirect_pc,
    output full, drop_count
  );
endinterface

// File: rtl/btb_update_queue.sv
// BTB update queue: detects mispredictions at branch resolution, issues the
// fetch redirect, and buffers BTB writes in a coalescing FIFO drained on grant.
module btb_update_queue #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  btb_update_queue_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      pc_mem_r  [DEPTH];
  logic [31:0]      tgt_mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic [7:0]       drop_count_r;
  logic             mispredict_r;
  logic [31:0]      redirect_pc_r;

  logic             empty_s;
  logic             full_s;
  logic             deq_s;
  logic             mismatch_s;
  logic             enq_req_s;
  logic [PTR_W-1:0] last_idx_s;
  logic             tail_hit_s;
  logic             coalesce_s;
  logic             alloc_s;
  logic             drop_s;
  logic [31:0]      redirect_next_s;

  // Misprediction detection and enqueue/coalesce/drop decision for this cycle.
  always_comb begin
    empty_s         = (count_r == {CNT_W{1'b0}});
    full_s          = (count_r == FULL_CNT);
    deq_s           = bus.update_ready & ~empty_s;
    mismatch_s      = (bus.resolve_taken != bus.pred_taken) |
                      (bus.resolve_taken & bus.pred_taken &
                       (bus.pred_target != bus.resolve_target));
    enq_req_s       = bus.resolve_valid & bus.resolve_taken &
                      (~bus.pred_taken | (bus.pred_target != bus.resolve_target));
    last_idx_s      = tail_r - PTR_W'(1);
    tail_hit_s      = ~empty_s & (pc_mem_r[last_idx_s] == bus.resolve_pc);
    // A lone entry leaving this cycle cannot absorb the new target; allocate instead.
    coalesce_s      = enq_req_s & tail_hit_s &
                      ~((count_r == CNT_W'(1)) & deq_s);
    alloc_s         = enq_req_s & ~coalesce_s & (~full_s | deq_s);
    drop_s          = enq_req_s & ~coalesce_s & ~alloc_s;
    if (bus.resolve_taken) begin
      redirect_next_s = bus.resolve_target;
    end else begin
      redirect_next_s = bus.resolve_pc + 32'd4;
    end
  end

  // Pointer, occupancy and drop-counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r       <= {PTR_W{1'b0}};
      tail_r       <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      drop_count_r <= 8'd0;
    end else begin
      if (deq_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      if (alloc_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      case ({alloc_s, deq_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s && (drop_count_r != 8'hFF)) begin
        drop_count_r <= drop_count_r + 8'd1;
      end
    end
  end

  // Entry storage; contents are only observed while counted as occupied.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (alloc_s) begin
        pc_mem_r[tail_r]  <= bus.resolve_pc;
        tgt_mem_r[tail_r] <= bus.resolve_target;
      end else if (coalesce_s) begin
        tgt_mem_r[last_idx_s] <= bus.resolve_target;
      end
    end
  end

  // One-cycle redirect pulse carrying the corrected fetch PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      mispredict_r  <= 1'b0;
      redirect_pc_r <= 32'd0;
    end else if (bus.resolve_valid && mismatch_s) begin
      mispredict_r  <= 1'b1;
      redirect_pc_r <= redirect_next_s;
    end else begin
      mispredict_r  <= 1'b0;
      redirect_pc_r <= 32'd0;
    end
  end

  assign bus.update      = deq_s;
  assign bus.update_addr = empty_s ? 32'd0 : pc_mem_r[head_r];
  assign bus.target_addr = empty_s ? 32'd0 : tgt_mem_r[head_r];
  assign bus.full        = full_s;
  assign bus.drop_count  = drop_count_r;
  assign bus.mispredict  = mispredict_r;
  assign bus.redirect_pc = redirect_pc_r;

endmodule

// File: tb/tb_btb_update_queue.sv
// Scoreboard bench for btb_update_queue: a reference queue of expected BTB
// writes is filled on resolve and popped/compared whenever update is expected.
module tb_btb_update_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
  } ent_t;

  logic clk;
  logic reset;
  btb_update_queue_if bus();

  btb_update_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          vectors;
  int          miscompares;
  ent_t        sb_q[$];
  logic        exp_mis;
  logic [31:0] exp_redir;
  logic [7:0]  exp_drop;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tg, input logic ptk, input logic [31:0] ptg);
    bus.resolve_valid  = v;
    bus.resolve_pc     = pc;
    bus.resolve_taken  = tk;
    bus.resolve_target = tg;
    bus.pred_taken     = ptk;
    bus.pred_target    = ptg;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  // Check current outputs against the model, advance the model, cross one edge.
  task automatic cycle();
    int   sz;
    ent_t head_e;
    ent_t e;
    logic exp_upd;
    logic mism;
    logic enq;
    logic coal;
    #1;
    sz      = sb_q.size();
    head_e  = (sz != 0) ? sb_q[0] : '0;
    exp_upd = bus.update_ready && (sz != 0);
    check_vec("update",      32'(bus.update),     32'(exp_upd));
    check_vec("update_addr", bus.update_addr,     head_e.pc);
    check_vec("target_addr", bus.target_addr,     head_e.tgt);
    check_vec("full",        32'(bus.full),       32'(sz == DEPTH));
    check_vec("drop_count",  32'(bus.drop_count), 32'(exp_drop));
    check_vec("mispredict",  32'(bus.mispredict), 32'(exp_mis));
    check_vec("redirect_pc", bus.redirect_pc,     exp_redir);
    if (reset) begin
      sb_q.delete();
      exp_drop  = 8'd0;
      exp_mis   = 1'b0;
      exp_redir = 32'd0;
    end else begin
      mism = bus.resolve_valid &&
             ((bus.resolve_taken != bus.pred_taken) ||
              (bus.resolve_taken && bus.pred_taken && bus.pred_target != bus.resolve_target));
      exp_mis   = mism;
      exp_redir = !mism ? 32'd0 :
                  (bus.resolve_taken ? bus.resolve_target : bus.resolve_pc + 32'd4);
      enq  = bus.resolve_valid && bus.resolve_taken &&
             (!bus.pred_taken || bus.pred_target != bus.resolve_target);
      coal = enq && (sz != 0) && (sb_q[sz-1].pc == bus.resolve_pc) &&
             !((sz == 1) && exp_upd);
      if (exp_upd) void'(sb_q.pop_front());
      if (coal) begin
        e     = sb_q[sb_q.size()-1];
        e.tgt = bus.resolve_target;
        sb_q[sb_q.size()-1] = e;
      end else if (enq) begin
        if ((sz < DEPTH) || exp_upd) begin
          e.pc  = bus.resolve_pc;
          e.tgt = bus.resolve_target;
          sb_q.push_back(e);
        end else if (exp_drop != 8'hFF) begin
          exp_drop = exp_drop + 8'd1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    idle();
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    clk              = 1'b0;
    reset            = 1'b1;
    vectors          = 0;
    miscompares      = 0;
    exp_mis          = 1'b0;
    exp_redir        = 32'd0;
    exp_drop         = 8'd0;
    bus.update_ready = 1'b0;
    idle();
    @(negedge clk);
    @(negedge clk);
    cycle();
    reset = 1'b0;

    // Idle after reset with the write port granted.
    bus.update_ready = 1'b1;
    idle_cycles(10);

    // Taken branch predicted not-taken: redirect and one BTB write.
    drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    cycle();
    idle_cycles(3);

    // Not-taken mispredict, then a correctly predicted taken branch.
    drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 32'h380);
    cycle();
    drive(1'b1, 32'h320, 1'b1, 32'h400, 1'b1, 32'h400);
    cycle();
    // Taken with wrong predicted target, back-to-back with the above.
    drive(1'b1, 32'h340, 1'b1, 32'h440, 1'b1, 32'h480);
    cycle();
    idle_cycles(3);

    // Overflow: five distinct mispredicts while the port is withheld.
    bus.update_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h1000 + 32'(i * 16), 1'b1, 32'h2000 + 32'(i * 16), 1'b0, 32'h0);
      cycle();
    end
    idle_cycles(3);
    bus.update_ready = 1'b1;
    idle_cycles(6);

    // Coalescing of repeated PC while held.
    bus.update_ready = 1'b0;
    drive(1'b1, 32'h400, 1'b1, 32'h500, 1'b0, 32'h0);
    cycle();
    drive(1'b1, 32'h400, 1'b1, 32'h600, 1'b0, 32'h0);
    cycle();
    idle_cycles(2);
    bus.update_ready = 1'b1;
    idle_cycles(3);

    // Same PC again while its lone entry drains: must allocate a second write.
    drive(1'b1, 32'h700, 1'b1, 32'h710, 1'b0, 32'h0);
    cycle();
    drive(1'b1, 32'h700, 1'b1, 32'h720, 1'b0, 32'h0);
    cycle();
    idle_cycles(3);

    // Full FIFO with simultaneous enqueue and dequeue.
    bus.update_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h800 + 32'(i * 4), 1'b1, 32'h900 + 32'(i * 4), 1'b0, 32'h0);
      cycle();
    end
    bus.update_ready = 1'b1;
    drive(1'b1, 32'h880, 1'b1, 32'h990, 1'b0, 32'h0);
    cycle();
    idle_cycles(6);

    // PC wrap on not-taken redirect.
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h10);
    cycle();
    idle_cycles(2);

    // Reset concurrent with a mispredicting resolve and a pending entry.
    bus.update_ready = 1'b0;
    drive(1'b1, 32'hA00, 1'b1, 32'hB00, 1'b0, 32'h0);
    cycle();
    reset = 1'b1;
    drive(1'b1, 32'hA10, 1'b1, 32'hB10, 1'b0, 32'h0);
    cycle();
    reset = 1'b0;
    bus.update_ready = 1'b1;
    idle_cycles(3);

    // Random traffic over a small PC set to exercise coalescing and drops.
    for (int i = 0; i < 400; i++) begin
      bus.update_ready = 1'($urandom_range(0, 3) == 0);
      drive(1'($urandom_range(0, 1)),
            32'h40 + 32'($urandom_range(0, 2) * 4),
            1'($urandom_range(0, 1)),
            32'h80 + 32'($urandom_range(0, 3) * 4),
            1'($urandom_range(0, 1)),
            32'h80 + 32'($urandom_range(0, 3) * 4));
      cycle();
    end
    bus.update_ready = 1'b1;
    idle_cycles(DEPTH + 2);

    // Drop counter saturation.
    bus.update_ready = 1'b0;
    for (int i = 0; i < 264; i++) begin
      drive(1'b1, 32'h1_0000 + 32'(i * 4), 1'b1, 32'h2_0000 + 32'(i * 4), 1'b0, 32'h0);
      cycle();
    end
    bus.update_ready = 1'b1;
    idle_cycles(DEPTH + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btb_update_queue.md
# btb_update_queue

Update-side companion to the 16-entry branch target buffer. It takes resolved branches from the execute stage, detects mispredictions against the fetch-time BTB prediction, generates the pipeline redirect, and drives the BTB write port (`update`, `update_addr`, `target_addr`) from a small coalescing FIFO. The FIFO drains only when the shared BTB write port is granted. It sits between execute-stage branch resolution and the BTB.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `resolve_valid`  in  1  one resolved branch/jump this cycle.
- `resolve_pc`  in  32  address of the resolved instruction.
- `resolve_taken`  in  1  actual direction.
- `resolve_target`  in  32  actual target; meaningful when taken.
- `pred_taken`  in  1  fetch-time BTB `match`, carried down the pipe.
- `pred_target`  in  32  fetch-time BTB `target`, carried down the pipe.
- `update_ready`  in  1  BTB write-port grant for this cycle.
- `update`  out  1  BTB write strobe.
- `update_addr`  out  32  head entry branch PC.
- `target_addr`  out  32  head entry target.
- `mispredict`  out  1  registered one-cycle redirect pulse.
- `redirect_pc`  out  32  correct fetch PC; valid while `mispredict` is high.
- `full`  out  1  FIFO holds DEPTH entries.
- `drop_count`  out  8  saturating count of discarded updates.

## Operation
Misprediction detection, evaluated when `resolve_valid` is high:
- Mispredict when `resolve_taken != pred_taken`, or when both are 1 and `pred_target != resolve_target`.
- `redirect_pc` = `resolve_target` if taken; otherwise `resolve_pc + 4`, computed modulo 2^32 (0xFFFFFFFC wraps to 0).

Enqueue condition: `resolve_valid & resolve_taken & (!pred_taken | pred_target != resolve_target)`.
- Not-taken branches never enqueue. The BTB has no invalidate, so stale entries are corrected only by later taken resolutions.
- Correctly predicted taken branches never enqueue.

Coalescing:
- If the FIFO is non-empty and `resolve_pc` equals the PC of the tail (youngest) entry, the tail target is overwritten. No new entry is allocated.
- Exception: if the tail is also the head and is being dequeued this cycle, a new entry is allocated instead.

FIFO behaviour:
- Circular buffer of {pc, target}, with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy count of log2(DEPTH)+1 bits.
- Dequeue occurs when `update` is high.
- Simultaneous enqueue and dequeue: count is unchanged. This is permitted when full, because the freed slot takes the new entry.
- Enqueue when full with no dequeue and no coalesce: the new entry is dropped and `drop_count` increments, saturating at 255. FIFO contents are unchanged.

Outputs:
- `update` = `update_ready & (count != 0)`. Combinational; no dependency on same-cycle resolve inputs.
- `update_addr` and `target_addr` always present the head entry. They are 0 when empty.
- `full` = (count == DEPTH).

## Timing
- Reset values: `update`=0, `update_addr`=0, `target_addr`=0, `mispredict`=0, `redirect_pc`=0, `full`=0, `drop_count`=0. Reset empties the FIFO and discards pending entries.
- Reset wins over a same-cycle resolve: nothing is enqueued and no `mispredict` is produced the next cycle.
- `mispredict` and `redirect_pc` latency: resolve sampled at edge N, outputs high for exactly cycle N+1.
- Back-to-back mispredicting resolves give back-to-back pulses, each carrying its own `redirect_pc`.
- Enqueue-to-update latency: an entry enqueued at edge N into an empty FIFO can drive `update` in cycle N+1, given `update_ready`. There is no bypass in the same cycle.
- Head advances at the edge where `update` is high; the next entry is visible the following cycle.
- Throughput: one enqueue and one dequeue per cycle.
- `update_ready` low holds the head stable indefinitely. No entry is lost except by overflow drop.

## Test plan
- Reset then idle: all outputs 0. Hold `update_ready`=1 for 10 cycles -> `update` never asserts.
- Resolve pc=0x100, taken, target=0x200, pred_taken=0 -> cycle+1: `mispredict`=1, `redirect_pc`=0x200; `update`=1 with addr 0x100 / target 0x200; FIFO empty after.
- Resolve pc=0x300, not taken, pred_taken=1 -> `mispredict`=1, `redirect_pc`=0x304, no `update`. Correctly predicted taken (pred_target=resolve_target) -> no `mispredict`, no `update`.
- `update_ready`=0, five distinct taken mispredicts with DEPTH=4 -> `full`=1, `drop_count`=1. Raise `update_ready` -> four updates drain in enqueue order on consecutive cycles.
- Two resolves of pc=0x400, targets 0x500 then 0x600, with `update_ready`=0 -> one entry. On release: single `update` with target 0x600.
- Resolve at pc=0xFFFFFFFC, not taken, mispredicted -> `redirect_pc`=0x00000000. Assert `reset` alongside a resolve -> no `mispredict` the next cycle, FIFO empty.
